// File: rtl/regfile_sb.sv
// Two-writeback-port integer register file with per-register pending-write counters.
// Optional build macro REGFILE_BYPASS_EN: forward same-cycle writeback data/busy to the read ports.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  input  logic             wa_en,
  input  logic [AW-1:0]    wa_addr,
  input  logic [XLEN-1:0]  wa_data,
  input  logic             wl_en,
  input  logic [AW-1:0]    wl_addr,
  input  logic [XLEN-1:0]  wl_data,
  input  logic [2:0]       wl_funct3,
  output logic [2**AW-1:0] busy_vec,
  output logic             wl_err
);

  localparam int unsigned NREG = 2**AW;
  localparam logic [CW-1:0] CMAX = '1;

  logic [XLEN-1:0] mem     [NREG];
  logic [XLEN-1:0] mem_nxt [NREG];
  logic [CW-1:0]   cnt     [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [CW:0]     dec     [NREG];
  logic [CW:0]     sum     [NREG];
  logic            hit_a   [NREG];
  logic            hit_l   [NREG];
  logic            inc     [NREG];

  logic [XLEN-1:0] wl_ext;
  logic            wl_legal;
  logic            iss_acc;

  always_comb begin
    wl_ext   = wl_data;
    wl_legal = 1'b1;
    case (wl_funct3)
      3'b000:  wl_ext = {{(XLEN-8){wl_data[7]}}, wl_data[7:0]};
      3'b001:  wl_ext = {{(XLEN-16){wl_data[15]}}, wl_data[15:0]};
      3'b010:  wl_ext = wl_data;
      3'b100:  wl_ext = {{(XLEN-8){1'b0}}, wl_data[7:0]};
      3'b101:  wl_ext = {{(XLEN-16){1'b0}}, wl_data[15:0]};
      default: wl_legal = 1'b0;
    endcase
  end

  assign iss_ready = (iss_rd == '0) || (cnt[iss_rd] != CMAX);
  assign iss_acc   = iss_valid && iss_ready && (iss_rd != '0);

  // An accepted issue never pushes the counter past max, so only the floor needs clamping.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      hit_a[i] = wa_en && (wa_addr == AW'(i));
      hit_l[i] = wl_en && (wl_addr == AW'(i));
      inc[i]   = iss_acc && (iss_rd == AW'(i));
      dec[i]   = {{CW{1'b0}}, hit_a[i]} + {{CW{1'b0}}, hit_l[i]};
      sum[i]   = {1'b0, cnt[i]} + {{CW{1'b0}}, inc[i]};
      cnt_nxt[i] = (sum[i] > dec[i]) ? CW'(sum[i] - dec[i]) : '0;
      mem_nxt[i] = mem[i];
      if (hit_l[i] && wl_legal)
        mem_nxt[i] = wl_ext;
      else if (hit_a[i])
        mem_nxt[i] = wa_data;
      if (i == 0) begin
        cnt_nxt[i] = '0;
        mem_nxt[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
        cnt[i] <= '0;
      end
      wl_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= mem_nxt[i];
        cnt[i] <= cnt_nxt[i];
      end
      wl_err <= wl_en && !wl_legal;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++)
      busy_vec[i] = (cnt[i] != '0);
  end

`ifdef REGFILE_BYPASS_EN
  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] a);
    if (a != '0 && wl_en && wl_legal && wl_addr == a)
      return wl_ext;
    else if (a != '0 && wa_en && wa_addr == a)
      return wa_data;
    else
      return mem[a];
  endfunction

  // Busy reflects this cycle's writebacks but not this cycle's issue.
  assign rs1_data = fwd(rs1_addr);
  assign rs2_data = fwd(rs2_addr);
  assign rs1_busy = ({1'b0, cnt[rs1_addr]} > dec[rs1_addr]);
  assign rs2_busy = ({1'b0, cnt[rs2_addr]} > dec[rs2_addr]);
`else
  assign rs1_data = mem[rs1_addr];
  assign rs2_data = mem[rs2_addr];
  assign rs1_busy = (cnt[rs1_addr] != '0);
  assign rs2_busy = (cnt[rs2_addr] != '0);
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expectations, a negedge monitor compares.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wa_en;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wl_en;
  logic [4:0]  wl_addr;
  logic [31:0] wl_data;
  logic [2:0]  wl_funct3;
  logic [31:0] busy_vec;
  logic        wl_err;

  regfile_sb #(.XLEN(32), .AW(5), .CW(2)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wl_en(wl_en), .wl_addr(wl_addr), .wl_data(wl_data), .wl_funct3(wl_funct3),
    .busy_vec(busy_vec), .wl_err(wl_err)
  );

  always #5 clk = ~clk;

  localparam int K_RS1 = 0, K_RS2 = 1, K_B1 = 2, K_B2 = 3, K_BV = 4, K_RDY = 5, K_ERR = 6;

  int          q_kind[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  int          errors = 0;
  int          checks = 0;

  task automatic expect_val(input int k, input logic [31:0] v, input string n);
    q_kind.push_back(k);
    q_exp.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are stable mid-cycle, so drain all pending expectations each negedge.
  always @(negedge clk) begin
    while (q_kind.size() > 0) begin
      int          k;
      logic [31:0] e;
      logic [31:0] a;
      string       n;
      k = q_kind.pop_front();
      e = q_exp.pop_front();
      n = q_name.pop_front();
      case (k)
        K_RS1:   a = rs1_data;
        K_RS2:   a = rs2_data;
        K_B1:    a = {31'd0, rs1_busy};
        K_B2:    a = {31'd0, rs2_busy};
        K_BV:    a = busy_vec;
        K_RDY:   a = {31'd0, iss_ready};
        default: a = {31'd0, wl_err};
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  task automatic idle();
    iss_valid = 1'b0; wa_en = 1'b0; wl_en = 1'b0;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d, input logic [2:0] f);
    wl_en = 1'b1; wl_addr = a; wl_data = d; wl_funct3 = f;
  endtask

  initial begin
    logic [2:0]  f3  [4];
    logic [31:0] ex3 [4];
    f3[0] = 3'b000; ex3[0] = 32'hFFFF_FF80;
    f3[1] = 3'b001; ex3[1] = 32'hFFFF_8F80;
    f3[2] = 3'b100; ex3[2] = 32'h0000_0080;
    f3[3] = 3'b101; ex3[3] = 32'h0000_8F80;

    rst = 1'b1;
    rs1_addr = '0; rs2_addr = '0; iss_rd = '0;
    wa_addr = '0; wa_data = '0; wl_addr = '0; wl_data = '0; wl_funct3 = '0;
    idle();
    tick();
    expect_val(K_BV, 32'd0, "reset_busy_vec");
    expect_val(K_RDY, 32'd1, "reset_iss_ready");
    expect_val(K_ERR, 32'd0, "reset_wl_err");
    tick();
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      expect_val(K_RS1, 32'd0, $sformatf("reset_rs1_x%0d", a));
      expect_val(K_RS2, 32'd0, $sformatf("reset_rs2_x%0d", 31 - a));
      expect_val(K_B1, 32'd0, "reset_rs1_busy");
      tick();
    end

    // Reset asserted during a write: array cleared at once, write lost.
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h1111_1111;
    tick();
    idle(); rs1_addr = 5'd4;
    expect_val(K_RS1, 32'h1111_1111, "x4_written");
    tick();
    wa_en = 1'b1; wa_data = 32'h2222_2222; rst = 1'b1;
    #1;
    expect_val(K_RS1, 32'd0, "x4_async_reset");
    tick();
    rst = 1'b0; idle();
    expect_val(K_RS1, 32'd0, "x4_write_dropped");
    tick();

    // Load extension on x5.
    for (int i = 0; i < 4; i++) begin
      load(5'd5, 32'h0000_8F80, f3[i]);
      tick();
      idle(); rs1_addr = 5'd5;
      expect_val(K_RS1, ex3[i], $sformatf("ext_f3_%0d", f3[i]));
      expect_val(K_ERR, 32'd0, "ext_no_err");
      expect_val(K_B1, 32'd0, "ext_busy_sat");
    end
    load(5'd5, 32'h1234_5678, 3'b011);
    tick();
    idle();
    expect_val(K_RS1, 32'h0000_8F80, "illegal_no_write");
    expect_val(K_ERR, 32'd1, "illegal_err_pulse");
    tick();
    expect_val(K_ERR, 32'd0, "illegal_err_one_cycle");
    load(5'd5, 32'h1234_5678, 3'b111);
    tick();
    idle();
    expect_val(K_ERR, 32'd1, "illegal111_err");
    expect_val(K_RS1, 32'h0000_8F80, "illegal111_no_write");
    tick();

    // Three issues saturate x7, fourth ignored.
    iss_valid = 1'b1; iss_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin
      expect_val(K_RDY, 32'd1, $sformatf("issue7_ready_%0d", i));
      tick();
    end
    expect_val(K_RDY, 32'd0, "issue7_full");
    expect_val(K_BV, 32'h0000_0080, "issue7_busy_vec");
    tick();
    idle(); rs1_addr = 5'd7;
    expect_val(K_B1, 32'd1, "x7_busy");
    for (int i = 0; i < 3; i++) begin
      wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hC0DE_0000 + 32'(i);
      tick();
      idle();
      expect_val(K_B1, (i < 2) ? 32'd1 : 32'd0, $sformatf("x7_busy_after_wb%0d", i + 1));
      expect_val(K_RDY, 32'd1, "x7_ready_after_wb");
    end
    expect_val(K_RS1, 32'hC0DE_0002, "x7_data");
    expect_val(K_BV, 32'd0, "x7_busy_vec_clear");
    tick();

    // Issue and two writebacks to x9 in one cycle.
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    rs1_addr = 5'd9;
    expect_val(K_B1, 32'd1, "x9_pending");
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hAAAA_0000;
    load(5'd9, 32'h1234_5678, 3'b010);
    tick();
    idle();
    expect_val(K_RS1, 32'h1234_5678, "x9_port_b_wins");
    expect_val(K_B1, 32'd0, "x9_counter_zero");
    expect_val(K_BV, 32'd0, "x9_busy_vec");
    tick();

    // x0 is immutable and never busy.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hDEAD_BEEF;
    load(5'd0, 32'hDEAD_BEEF, 3'b010);
    iss_valid = 1'b1; iss_rd = 5'd0;
    rs2_addr = 5'd0;
    expect_val(K_RDY, 32'd1, "x0_iss_ready");
    expect_val(K_RS2, 32'd0, "x0_read_during_write");
    tick();
    idle();
    expect_val(K_RS2, 32'd0, "x0_reads_zero");
    expect_val(K_BV, 32'd0, "x0_not_busy");
    expect_val(K_B2, 32'd0, "x0_rs2_busy");
    tick();

    // Same-cycle read of a register being written.
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_5555;
    tick();
    idle();
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_1234;
    rs1_addr = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_val(K_RS1, 32'h0000_1234, "x3_bypass_same_cycle");
`else
    expect_val(K_RS1, 32'h0000_5555, "x3_old_same_cycle");
`endif
    tick();
    idle();
    expect_val(K_RS1, 32'h0000_1234, "x3_next_cycle");
    wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h0000_AAAA;
    load(5'd3, 32'h0000_0080, 3'b000);
    rs2_addr = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_val(K_RS2, 32'hFFFF_FF80, "x3_bypass_port_b");
`else
    expect_val(K_RS2, 32'h0000_1234, "x3_old_both_ports");
`endif
    tick();
    idle();
    expect_val(K_RS2, 32'hFFFF_FF80, "x3_port_b_final");
    tick();
    tick();

    if (q_kind.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_kind.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the pipelined core with two writeback ports: ALU writeback and load writeback with byte/halfword extension. A per-register pending-write scoreboard lets decode detect RAW hazards and stall. It sits between decode (read, issue) and the writeback stage, and replaces the single-write-port register file.

## Interface
- XLEN, 32, data width in bits (≥16)
- AW, 5, register address width; NREG = 2**AW registers
- CW, 2, scoreboard counter width; max outstanding writes per register = 2**CW−1

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  combinational read data
- rs1_busy, rs2_busy  out  1  register has pending writes
- iss_valid  in  1  decode issues an instruction that will write iss_rd
- iss_rd  in  AW  destination of the issuing instruction
- iss_ready  out  1  combinational; iss_rd counter below max, or iss_rd==0
- wa_en, wa_addr[AW], wa_data[XLEN]  in  port A (ALU writeback), full-word write
- wl_en, wl_addr[AW], wl_data[XLEN], wl_funct3[3]  in  port B (load writeback)
- busy_vec  out  NREG  bit i = (counter i != 0)
- wl_err  out  1  registered one-cycle pulse: illegal wl_funct3 seen

## Operation
- Storage: NREG×XLEN array plus NREG×CW pending counters. Register 0 reads 0, is never written, and its counter stays 0.
- Port B extension by wl_funct3:
  - 000: sign-extend [7:0]
  - 001: sign-extend [15:0]
  - 010: full word
  - 100: zero-extend [7:0]
  - 101: zero-extend [15:0]
  - 011/110/111: illegal. No data write; counter still decrements; wl_err=1 next cycle.
- Both ports writing the same nonzero register in one cycle: port B data wins.
- Issue: iss_valid && iss_ready && iss_rd!=0 increments counter[iss_rd]. Issue with iss_ready=0 is ignored; decode must stall.
- Writeback: each enabled port decrements its target counter by 1, saturating at 0. A writeback to a register whose counter is 0 still writes data.
- Same register, same cycle, net counter change = (+1 if issue accepted) − (number of enabled write ports targeting it), clamped to [0, max].
- rsN_busy = counter[rsN_addr]!=0 (see Configuration). Always 0 for address 0.

## Timing
- Reset: array all 0, counters all 0, wl_err=0. So rs1_data=rs2_data=0, rsN_busy=0, busy_vec=0, iss_ready=1.
- Reset asserted mid-operation clears everything immediately. Writes and issues in that cycle are lost.
- Data write, counter update and wl_err all take effect at posedge. Read latency is 0 (combinational from array).
- Without bypass, a value written at edge k is readable after edge k; a read in the write cycle returns old data.
- wl_err is high exactly one cycle per illegal load writeback.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rsN_data forwards same-cycle write data when the address matches an enabled write to a nonzero register. Port B (extended) has priority over port A. Illegal funct3 is not forwarded.
  - rsN_busy reflects the counter after this cycle's decrements; same-cycle issue is not included.
- REGFILE_BYPASS_EN undefined: reads and busy come only from registered state.

## Test plan
- Reset, then read all 32 registers -> all data 0, busy_vec=0, iss_ready=1. Assert rst mid-write -> write dropped.
- wl_data=0x0000_8F80, wl_addr=5:
  - funct3=000 -> x5=0xFFFF_FF80
  - 001 -> 0xFFFF_8F80
  - 100 -> 0x0000_0080
  - 101 -> 0x0000_8F80
  - 011 -> x5 unchanged, wl_err pulse 1 cycle
- Issue rd=7 three times -> counter 3, iss_ready=0 for rd=7. Fourth issue ignored. Three wa writebacks -> rs1_busy low after the third.
- Same cycle: issue rd=9, wa and wl both to 9 with counter=1 -> x9 gets port B data, counter 0.
- Write 0xDEAD_BEEF to x0 via both ports, issue rd=0 -> x0 reads 0, busy_vec[0]=0.
- Bypass build: wa to x3=0x1234 while rs1_addr=3 -> rs1_data=0x1234 same cycle. Non-bypass build -> old value, new value next cycle.
